cnn_stream_conv: RTL and testbench
==================================

# cnn_stream_conv

Streaming 2-D convolution engine that supersedes the fixed-kernel pixel filter: same line-buffer-plus-MAC structure, but with a runtime-loadable signed kernel, parametrised kernel size, stride 1/2, programmable normalisation shift, ready/valid backpressure on both sides and a frame-level control FSM. It sits between the pixel source and downstream feature-map logic, accepting one raster-order pixel per handshake and emitting one "valid" (unpadded) convolution result per window.

## Interface
- PIXEL_WIDTH, 8, unsigned input/output pixel width
- KERNEL_WIDTH, 5, signed two's-complement coefficient width
- KERNEL_SIZE, 3, square window size K (odd, 3..7)
- MAX_LINE_LENGTH, 2000, max frame columns; line-buffer depth
- MAX_SHIFT, 15, max normalisation right shift
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse (accepted in IDLE only)
- frame_cols  in  clog2(MAX_LINE_LENGTH+1)  columns, sampled on accepted start
- frame_rows  in  16  rows, sampled on accepted start
- stride2  in  1  0: stride 1, 1: stride 2; sampled on accepted start
- norm_shift  in  clog2(MAX_SHIFT+1)  arithmetic right shift of sum; sampled on accepted start
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(K*K)  row-major index (row*K+col)
- coef_data  in  KERNEL_WIDTH  signed coefficient
- in_valid / in_ready  in / out  1  pixel handshake
- in_pixel  in  PIXEL_WIDTH  pixel, raster order
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  PIXEL_WIDTH  saturated result
- out_last  out  1  high with final result of frame
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse at frame end

## Operation
- FSM states IDLE, RUN, DRAIN. IDLE→RUN on start when frame_cols ≥ K, frame_rows ≥ K, frame_cols ≤ MAX_LINE_LENGTH; otherwise start ignored. RUN→DRAIN on acceptance of pixel (frame_rows-1, frame_cols-1). DRAIN→IDLE when final result handshakes; frame_done pulses that cycle.
- in_ready = (state==RUN) && !stall; stall = out_valid && !out_ready. Stall freezes every pipeline stage.
- Row/column counters advance per accepted pixel; column wraps at frame_cols-1, incrementing row.
- K-1 line buffers plus K×K window register; buffer contents need no reset (gated by counters).
- Window emitted when row ≥ K-1, col ≥ K-1 and, for stride2, (row-K+1) and (col-K+1) both even. Result count per frame = (⌊(rows-K)/s⌋+1)·(⌊(cols-K)/s⌋+1).
- Arithmetic: pixel zero-extended to signed PIXEL_WIDTH+1; products PIXEL_WIDTH+KERNEL_WIDTH+1 bits; sum grows by clog2(K*K) bits, no overflow. sum >>> norm_shift, then negative handling (Configuration), then clamp to 2^PIXEL_WIDTH-1.
- Coefficients: coef_we honoured in IDLE only; ignored in RUN/DRAIN. Reset value is identity kernel (centre = 1, rest 0).
- start while busy ignored.

## Timing
- Reset: state IDLE, in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, frame_done 0, counters 0, kernel identity.
- Pipeline: acceptance edge E0 updates window; E1 registers products; E2 registers out_data/out_valid. Latency 2 cycles with no stall; throughput one pixel/cycle.
- out_valid/out_data/out_last hold stable until out_ready sampled high.
- busy rises the cycle after accepted start; in_ready rises the same cycle.
- Reset mid-frame aborts immediately; no frame_done, partial outputs discarded.
- Simultaneous coef_we and start in IDLE: write takes effect, new kernel used for that frame.

## Configuration
- CNN_STREAM_ABS_EN defined: negative shifted sums replaced by magnitude (edge-detect use), then saturated.
- Undefined: negative shifted sums clamp to 0 (ReLU).

## Test plan
- Identity kernel, 4×4 frame, pixels 0..15, stride 1 → 4 outputs 5,6,9,10; out_last on 10; frame_done one cycle after.
- All-ones 3×3 kernel, norm_shift 3, constant 16 on 5×5 → nine outputs of 18; constant 255, shift 0 → 255 (saturation).
- Laplacian (centre -4, edges 1, corners 0) on 3×3 with centre 100, rest 0 → 0 without macro, 255 with CNN_STREAM_ABS_EN (400 saturated).
- Stride2, 6×6 ramp 0..35, identity → 4 outputs 7,9,19,21.
- out_ready toggled 1-0-0-1 randomly, in_valid random → output sequence identical to no-stall run; in_ready low whenever out_valid && !out_ready.
- coef_we during RUN changes no results; start with frame_cols=2 ignored (busy stays 0); rst_n low mid-frame → all outputs reset values, next frame correct.

Source files
------------

// File: rtl/cnn_stream_conv.sv
// Streaming KxK convolution: runtime signed kernel, stride 1/2, ready/valid on both sides, frame FSM.
// Optional macro CNN_STREAM_ABS_EN: negative shifted sums use their magnitude instead of clamping to zero.
module cnn_stream_conv #(
  parameter  int PIXEL_WIDTH     = 8,
  parameter  int KERNEL_WIDTH    = 5,
  parameter  int KERNEL_SIZE     = 3,
  parameter  int MAX_LINE_LENGTH = 2000,
  parameter  int MAX_SHIFT       = 15,
  localparam int CW  = $clog2(MAX_LINE_LENGTH + 1),
  localparam int SHW = $clog2(MAX_SHIFT + 1),
  localparam int KK  = KERNEL_SIZE * KERNEL_SIZE,
  localparam int CAW = $clog2(KK)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic [CW-1:0]                  i_frame_cols,
  input  logic [15:0]                    i_frame_rows,
  input  logic                           i_stride2,
  input  logic [SHW-1:0]                 i_norm_shift,
  input  logic                           i_coef_we,
  input  logic [CAW-1:0]                 i_coef_addr,
  input  logic signed [KERNEL_WIDTH-1:0] i_coef_data,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [PIXEL_WIDTH-1:0]         i_in_pixel,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [PIXEL_WIDTH-1:0]         o_out_data,
  output logic                           o_out_last,
  output logic                           o_busy,
  output logic                           o_frame_done
);

  localparam int K   = KERNEL_SIZE;
  localparam int PW  = PIXEL_WIDTH;
  localparam int KW  = KERNEL_WIDTH;
  localparam int PRW = PW + KW + 1;
  localparam int SW  = PRW + CAW;
  localparam logic K_B0   = 1'(KERNEL_SIZE % 2);
  localparam logic KM1_B0 = 1'((KERNEL_SIZE - 1) % 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                r_state;
  logic [15:0]           r_row;
  logic [CW-1:0]         r_col;
  logic [15:0]           r_rows;
  logic [CW-1:0]         r_cols;
  logic [15:0]           r_last_row;
  logic [CW-1:0]         r_last_col;
  logic                  r_stride2;
  logic [SHW-1:0]        r_shift;
  logic                  r_last_done;
  logic                  r_frame_done;
  logic signed [KW-1:0]  r_coef [KK];

  logic [PW-1:0]         r_lb  [K-1][MAX_LINE_LENGTH];
  logic [PW-1:0]         r_win [KK];
  logic [PW-1:0]         w_tap [K-1];
  logic [PW-1:0]         w_col_in [K];

  logic                  r_v0, r_l0, r_v1, r_l1;
  logic signed [PRW-1:0] r_prod [KK];
  logic signed [PRW-1:0] w_prod [KK];
  logic                  r_out_valid;
  logic [PW-1:0]         r_out_data;
  logic                  r_out_last;

  logic signed [SW-1:0]  w_sum;
  logic signed [SW-1:0]  w_shr;
  logic signed [SW-1:0]  w_mag;
  logic [PW-1:0]         w_result;

  logic w_stall, w_accept, w_col_end, w_row_end, w_last_pix;
  logic w_hs_last, w_start_ok, w_emit, w_is_last_win;

  assign w_stall     = r_out_valid && !i_out_ready;
  assign o_in_ready  = (r_state == S_RUN) && !w_stall;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_col_end   = (r_col == r_cols - CW'(1));
  assign w_row_end   = (r_row == r_rows - 16'd1);
  assign w_last_pix  = w_col_end && w_row_end;
  assign w_hs_last   = r_out_valid && i_out_ready && r_out_last;
  assign w_start_ok  = i_start && (i_frame_cols >= CW'(K)) && (i_frame_rows >= 16'(K)) &&
                       (i_frame_cols <= CW'(MAX_LINE_LENGTH));

  // With stride 2 only windows whose offset from K-1 is even are emitted.
  assign w_emit = (r_row >= 16'(K - 1)) && (r_col >= CW'(K - 1)) &&
                  (!r_stride2 || ((r_row[0] == KM1_B0) && (r_col[0] == KM1_B0)));
  assign w_is_last_win = (r_row == r_last_row) && (r_col == r_last_col);

  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_last   = r_out_last;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;

  // State | meaning
  // IDLE  | waiting for a valid start; kernel writable
  // RUN   | accepting pixels until the last pixel of the frame
  // DRAIN | waiting for the final result to handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_rows       <= '0;
      r_cols       <= '0;
      r_last_row   <= '0;
      r_last_col   <= '0;
      r_stride2    <= 1'b0;
      r_shift      <= '0;
      r_last_done  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < KK; i++) r_coef[i] <= (i == KK / 2) ? KW'(1) : '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          for (int i = 0; i < KK; i++)
            if (i_coef_we && (i_coef_addr == CAW'(i))) r_coef[i] <= i_coef_data;
          if (w_start_ok) begin
            r_rows      <= i_frame_rows;
            r_cols      <= i_frame_cols;
            r_stride2   <= i_stride2;
            r_shift     <= i_norm_shift;
            r_row       <= '0;
            r_col       <= '0;
            r_last_done <= 1'b0;
            // Last emitted window: drop one row/column when stride 2 leaves an odd remainder.
            r_last_row  <= i_frame_rows - 16'd1 - {15'd0, i_stride2 & (i_frame_rows[0] ^ K_B0)};
            r_last_col  <= i_frame_cols - CW'(1) - {{(CW-1){1'b0}}, i_stride2 & (i_frame_cols[0] ^ K_B0)};
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_hs_last) r_last_done <= 1'b1;
          if (w_accept) begin
            if (w_col_end) begin
              r_col <= '0;
              r_row <= r_row + 16'd1;
            end else begin
              r_col <= r_col + CW'(1);
            end
            if (w_last_pix) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_hs_last || r_last_done) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < K - 1; k++) w_tap[k] = r_lb[k][r_col];
    w_col_in[K-1] = i_in_pixel;
    for (int k = 0; k < K - 1; k++) w_col_in[K-2-k] = w_tap[k];
  end

  // Line buffers and window are qualified by the counters, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][r_col] <= i_in_pixel;
      for (int k = 1; k < K - 1; k++) r_lb[k][r_col] <= w_tap[k-1];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) r_win[r*K+c] <= r_win[r*K+c+1];
        r_win[r*K+K-1] <= w_col_in[r];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < KK; i++)
      w_prod[i] = $signed({{(PRW-PW){1'b0}}, r_win[i]}) *
                  $signed({{(PRW-KW){r_coef[i][KW-1]}}, r_coef[i]});
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KK; i++)
      w_sum = w_sum + {{(SW-PRW){r_prod[i][PRW-1]}}, r_prod[i]};
    w_shr = w_sum >>> r_shift;
`ifdef CNN_STREAM_ABS_EN
    w_mag = w_shr[SW-1] ? -w_shr : w_shr;
`else
    w_mag = w_shr[SW-1] ? '0 : w_shr;
`endif
    if (|w_mag[SW-1:PW]) w_result = '1;
    else                 w_result = w_mag[PW-1:0];
  end

  // Every stage holds while the output register is waiting on the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0        <= 1'b0;
      r_l0        <= 1'b0;
      r_v1        <= 1'b0;
      r_l1        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < KK; i++) r_prod[i] <= '0;
    end else if (!w_stall) begin
      r_v0        <= w_accept && w_emit;
      r_l0        <= w_accept && w_emit && w_is_last_win;
      r_v1        <= r_v0;
      r_l1        <= r_l0;
      for (int i = 0; i < KK; i++) r_prod[i] <= w_prod[i];
      r_out_valid <= r_v1;
      r_out_last  <= r_v1 && r_l1;
      if (r_v1) r_out_data <= w_result;
    end
  end

endmodule

// File: tb/tb_cnn_stream_conv.sv
// Randomised bench for cnn_stream_conv, compared against a direct arithmetic convolution model.
module tb_cnn_stream_conv;
  localparam int PW = 8, KW = 5, K = 3, MAXL = 2000, MAXS = 15;
  localparam int CW = $clog2(MAXL + 1), SHW = $clog2(MAXS + 1), CAW = $clog2(K * K);

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [CW-1:0] frame_cols;
  logic [15:0] frame_rows;
  logic stride2;
  logic [SHW-1:0] norm_shift;
  logic coef_we;
  logic [CAW-1:0] coef_addr;
  logic signed [KW-1:0] coef_data;
  logic in_valid, in_ready;
  logic [PW-1:0] in_pixel;
  logic out_valid, out_ready;
  logic [PW-1:0] out_data;
  logic out_last, busy, frame_done;

  int n_chk = 0;
  int n_bad = 0;
  int g_kern[K*K];
  int g_pix[$];
  int g_exp[$];

  always #5 clk = ~clk;

  cnn_stream_conv dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_frame_cols(frame_cols),
    .i_frame_rows(frame_rows), .i_stride2(stride2), .i_norm_shift(norm_shift),
    .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_pixel(in_pixel),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_last(out_last), .o_busy(busy), .o_frame_done(frame_done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void build_exp(int rows, int cols, bit s2, int sh);
    int st;
    st = s2 ? 2 : 1;
    g_exp.delete();
    for (int r = K - 1; r < rows; r += st)
      for (int c = K - 1; c < cols; c += st) begin
        int acc;
        acc = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            acc += g_kern[i*K+j] * g_pix[(r-K+1+i)*cols + (c-K+1+j)];
        acc = acc >>> sh;
`ifdef CNN_STREAM_ABS_EN
        if (acc < 0) acc = -acc;
`else
        if (acc < 0) acc = 0;
`endif
        if (acc > 255) acc = 255;
        g_exp.push_back(acc);
      end
  endfunction

  task automatic set_kern_identity();
    for (int i = 0; i < K*K; i++) g_kern[i] = (i == (K*K)/2) ? 1 : 0;
  endtask

  task automatic write_kern();
    for (int i = 0; i < K*K; i++) begin
      @(negedge clk);
      coef_we = 1'b1; coef_addr = CAW'(i); coef_data = KW'(g_kern[i]);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic fill_pix(input int n, input int mode, input int v);
    g_pix.delete();
    for (int i = 0; i < n; i++)
      case (mode)
        0: g_pix.push_back(i % 256);
        1: g_pix.push_back(v);
        default: g_pix.push_back(int'($urandom_range(0, 255)));
      endcase
  endtask

  task automatic do_start(input int rows, input int cols, input bit s2, input int sh,
                          input int wa, input int wd);
    @(negedge clk);
    frame_rows = 16'(rows); frame_cols = CW'(cols); stride2 = s2;
    norm_shift = SHW'(sh); start = 1'b1; out_ready = 1'b1;
    if (wa >= 0) begin
      coef_we = 1'b1; coef_addr = CAW'(wa); coef_data = KW'(wd); g_kern[wa] = wd;
    end
    @(negedge clk);
    start = 1'b0; coef_we = 1'b0;
  endtask

  task automatic run_frame(input string nm, input int rows, input int cols, input bit s2,
                           input int sh, input bit rv, input bit rr, input bit poke,
                           input int wa, input int wd);
    int n_in, n_out, it, last_hs, done_at;
    bit stalled;
    logic [PW-1:0] held_d;
    logic held_l;
    n_in = 0; n_out = 0; it = 0; last_hs = -10; done_at = -1; stalled = 1'b0;
    held_d = '0; held_l = 1'b0;
    do_start(rows, cols, s2, sh, wa, wd);
    build_exp(rows, cols, s2, sh);
    #1;
    chk({nm, "/busy_rise"}, busy, 1);
    chk({nm, "/ready_rise"}, in_ready, 1);
    while (done_at < 0 && it < 4000) begin
      in_valid  = (n_in < g_pix.size()) && (rv ? ($urandom_range(0, 2) != 0) : 1'b1);
      in_pixel  = (n_in < g_pix.size()) ? PW'(g_pix[n_in]) : '0;
      out_ready = rr ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (poke) begin
        coef_we   = busy && ($urandom_range(0, 1) == 1);
        coef_addr = CAW'($urandom_range(0, K*K-1));
        coef_data = KW'($urandom_range(0, 31));
      end
      #1;
      if (stalled) begin
        chk({nm, "/hold_valid"}, out_valid, 1);
        chk({nm, "/hold_data"}, out_data, held_d);
        chk({nm, "/hold_last"}, out_last, held_l);
      end
      if (out_valid && !out_ready) chk({nm, "/stall_ready"}, in_ready, 0);
      if (frame_done) done_at = it;
      if (out_valid && out_ready) begin
        if (n_out < g_exp.size()) begin
          chk({nm, "/data"}, out_data, g_exp[n_out]);
          chk({nm, "/last"}, out_last, (n_out == g_exp.size() - 1) ? 1 : 0);
        end else begin
          chk({nm, "/extra_result"}, n_out, g_exp.size());
        end
        n_out++;
        last_hs = it;
      end
      stalled = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (in_valid && in_ready) n_in++;
      @(negedge clk);
      it++;
    end
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    chk({nm, "/frame_done_seen"}, (done_at >= 0) ? 1 : 0, 1);
    chk({nm, "/n_results"}, n_out, g_exp.size());
    chk({nm, "/n_pixels"}, n_in, g_pix.size());
    if (!s2) chk({nm, "/done_latency"}, done_at - last_hs, 1);
    #1;
    chk({nm, "/done_pulse_end"}, frame_done, 0);
    chk({nm, "/busy_fall"}, busy, 0);
  endtask

  initial begin
    int ign_r[3];
    int ign_c[3];
    rst_n = 1'b0; start = 1'b0; frame_cols = '0; frame_rows = '0; stride2 = 1'b0;
    norm_shift = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    set_kern_identity();
    repeat (3) @(negedge clk);
    #1;
    chk("rst/in_ready", in_ready, 0);
    chk("rst/out_valid", out_valid, 0);
    chk("rst/out_data", out_data, 0);
    chk("rst/out_last", out_last, 0);
    chk("rst/busy", busy, 0);
    chk("rst/frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // identity kernel out of reset
    fill_pix(16, 0, 0);
    run_frame("id4x4", 4, 4, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1, 0);

    for (int i = 0; i < K*K; i++) g_kern[i] = 1;
    write_kern();
    fill_pix(25, 1, 16);
    run_frame("ones16", 5, 5, 1'b0, 3, 1'b0, 1'b0, 1'b0, -1, 0);
    fill_pix(25, 1, 255);
    run_frame("ones255", 5, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1, 0);

    // Laplacian; centre coefficient written together with start
    g_kern = '{0, 1, 0, 1, 1, 1, 0, 1, 0};
    write_kern();
    fill_pix(9, 1, 0);
    g_pix[4] = 100;
    run_frame("lapl", 3, 3, 1'b0, 0, 1'b0, 1'b0, 1'b0, 4, -4);

    set_kern_identity();
    write_kern();
    fill_pix(36, 0, 0);
    run_frame("stride2", 6, 6, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1, 0);

    for (int f = 0; f < 8; f++) begin
      int rows, cols, sh;
      bit s2;
      for (int i = 0; i < K*K; i++) g_kern[i] = int'($urandom_range(0, 31)) - 16;
      write_kern();
      rows = int'($urandom_range(3, 7));
      cols = int'($urandom_range(3, 9));
      s2   = ($urandom_range(0, 1) == 1);
      sh   = int'($urandom_range(0, 6));
      fill_pix(rows * cols, 2, 0);
      run_frame("rand", rows, cols, s2, sh, 1'b1, 1'b1, 1'b0, -1, 0);
    end

    fill_pix(42, 2, 0);
    run_frame("coef_poke", 6, 7, 1'b0, 2, 1'b1, 1'b1, 1'b1, -1, 0);

    ign_r = '{5, 2, 5};
    ign_c = '{2, 5, 2001};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      frame_rows = 16'(ign_r[t]); frame_cols = CW'(ign_c[t]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("start_ignored/busy", busy, 0);
      chk("start_ignored/in_ready", in_ready, 0);
    end

    // abort mid-frame with a non-identity kernel loaded
    for (int i = 0; i < K*K; i++) g_kern[i] = 1;
    write_kern();
    fill_pix(36, 2, 0);
    do_start(6, 6, 1'b0, 3, -1, 0);
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_pixel = PW'(g_pix[i]); out_ready = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort/in_ready", in_ready, 0);
    chk("abort/out_valid", out_valid, 0);
    chk("abort/out_data", out_data, 0);
    chk("abort/out_last", out_last, 0);
    chk("abort/busy", busy, 0);
    chk("abort/frame_done", frame_done, 0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_kern_identity();
    fill_pix(30, 2, 0);
    run_frame("after_abort", 5, 6, 1'b0, 0, 1'b1, 1'b1, 1'b0, -1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
